// File: rtl/cam_pkg.sv
// Shared types and widths for the CAM search sequencer and its result FIFO.
package cam_pkg;

   localparam int CAM_DW = 32;
   localparam int CAM_AW = 8;
   localparam int CAM_MW = 3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARM,
      ST_WAIT,
      ST_ACK,
      ST_NEXT,
      ST_DONE
   } state_e;

   typedef struct packed {
      logic [CAM_MW-1:0] mask;
      logic [CAM_AW-1:0] addr;
      logic [CAM_DW-1:0] data;
   } cam_res_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/cam_search_ctrl_if.sv
// Control, CAM-side and result-side signals of the search sequencer.
interface cam_search_ctrl_if;
   import cam_pkg::*;

   logic              start;
   logic [CAM_MW-1:0] strb_cfg;
   logic              busy;
   logic              done;
   logic [CAM_MW-1:0] cam_mask;
   logic [CAM_MW-1:0] cam_strb;
   logic              cam_mask_en;
   logic              cam_hit;
   logic [CAM_DW-1:0] cam_data;
   logic [CAM_AW-1:0] cam_addr;
   logic              cam_ack;
   logic              res_valid;
   logic              res_ready;
   logic [CAM_DW-1:0] res_data;
   logic [CAM_AW-1:0] res_addr;
   logic [CAM_MW-1:0] res_mask;
   logic [15:0]       hit_cnt;

   modport master (
      input  start, strb_cfg, cam_hit, cam_data, cam_addr, res_ready,
      output busy, done, cam_mask, cam_strb, cam_mask_en, cam_ack,
             res_valid, res_data, res_addr, res_mask, hit_cnt
   );

   modport slave (
      output start, strb_cfg, cam_hit, cam_data, cam_addr, res_ready,
      input  busy, done, cam_mask, cam_strb, cam_mask_en, cam_ack,
             res_valid, res_data, res_addr, res_mask, hit_cnt
   );

endinterface

// File: rtl/cam_res_fifo.sv
// Synchronous FIFO of search results; push and pop in one cycle are both honoured,
// including a push into a full FIFO that is being popped.
module cam_res_fifo
   import cam_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     push_i,
   input  logic     pop_i,
   input  cam_res_t wdata_i,
   output cam_res_t rdata_o,
   output logic     full_o,
   output logic     empty_o
);
   localparam int PW = $clog2(DEPTH);

   cam_res_t       mem_q [DEPTH];
   logic [PW:0]    wr_q;
   logic [PW:0]    rd_q;
   logic           do_push;
   logic           do_pop;

   assign empty_o = (wr_q == rd_q);
   assign full_o  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign rdata_o = mem_q[rd_q[PW-1:0]];

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop)  rd_q <= rd_q + 1'b1;
      end
   end

   // NOTE: storage is not reset; the pointers alone define which entries are live.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q[PW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/cam_search_ctrl.sv
// Mask-sweep sequencer: arms each mask, acknowledges CAM hits into the result FIFO,
// and advances on a no-hit timeout or when the per-mask hit cap is reached.
module cam_search_ctrl
   import cam_pkg::*;
#(
   parameter int FIFO_DEPTH  = 8,
   parameter int HIT_TIMEOUT = 15
) (
   input logic               clk,
   input logic               rst,
   cam_search_ctrl_if.master bus
);
   localparam int              TMO_W        = $clog2(HIT_TIMEOUT + 1);
   localparam logic [CAM_AW:0] MASK_HIT_CAP = {1'b1, {CAM_AW{1'b0}}};

   state_e            state_q, state_d;
   logic [CAM_MW-1:0] mask_q, mask_d;
   logic [CAM_MW-1:0] strb_q, strb_d;
   logic [15:0]       hit_cnt_q, hit_cnt_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic [CAM_AW:0]   mhit_q, mhit_d;

   logic     busy, done, mask_en, ack, push;
   logic     pop, can_accept, fifo_full, fifo_empty;
   cam_res_t push_res, head_res;

   assign pop        = !fifo_empty && bus.res_ready;
   assign can_accept = !fifo_full || pop;
   assign push_res   = '{mask: mask_q, addr: bus.cam_addr, data: bus.cam_data};

   cam_res_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (push_res),
      .rdata_o (head_res),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         mask_q    <= '0;
         strb_q    <= '0;
         hit_cnt_q <= '0;
         tmo_q     <= '0;
         mhit_q    <= '0;
      end else begin
         state_q   <= state_d;
         mask_q    <= mask_d;
         strb_q    <= strb_d;
         hit_cnt_q <= hit_cnt_d;
         tmo_q     <= tmo_d;
         mhit_q    <= mhit_d;
      end
   end

   // NOTE: every output of this block gets a default first so no path infers a latch.
   always_comb begin
      state_d   = state_q;
      mask_d    = mask_q;
      strb_d    = strb_q;
      hit_cnt_d = hit_cnt_q;
      tmo_d     = tmo_q;
      mhit_d    = mhit_q;
      busy      = 1'b1;
      done      = 1'b0;
      mask_en   = 1'b0;
      ack       = 1'b0;
      push      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            busy = 1'b0;
            if (bus.start) begin
               strb_d    = bus.strb_cfg;
               mask_d    = '0;
               hit_cnt_d = '0;
               state_d   = ST_ARM;
            end
         end
         ST_ARM: begin
            mask_en = 1'b1;
            tmo_d   = '0;
            mhit_d  = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            mask_en = 1'b1;
            if (bus.cam_hit) begin
               // A hit blocked by a full FIFO holds here without aging the timeout.
               if (can_accept) begin
                  push      = 1'b1;
                  hit_cnt_d = sat_inc16(hit_cnt_q);
                  mhit_d    = mhit_q + 1'b1;
                  state_d   = ST_ACK;
               end
            end else begin
               tmo_d = tmo_q + 1'b1;
               if (tmo_q == TMO_W'(HIT_TIMEOUT - 1)) state_d = ST_NEXT;
            end
         end
         ST_ACK: begin
            mask_en = 1'b1;
            ack     = 1'b1;
            tmo_d   = '0;
            state_d = (mhit_q == MASK_HIT_CAP) ? ST_NEXT : ST_WAIT;
         end
         ST_NEXT: begin
            if (mask_q == '1) begin
               state_d = ST_DONE;
            end else begin
               mask_d  = mask_q + 1'b1;
               state_d = ST_ARM;
            end
         end
         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.busy        = busy;
   assign bus.done        = done;
   assign bus.cam_mask    = mask_q;
   assign bus.cam_strb    = strb_q;
   assign bus.cam_mask_en = mask_en;
   assign bus.cam_ack     = ack;
   assign bus.hit_cnt     = hit_cnt_q;
   assign bus.res_valid   = !fifo_empty;
   assign bus.res_data    = fifo_empty ? '0 : head_res.data;
   assign bus.res_addr    = fifo_empty ? '0 : head_res.addr;
   assign bus.res_mask    = fifo_empty ? '0 : head_res.mask;

endmodule

// File: tb/tb_cam_search_ctrl.sv
// Scoreboard bench: a behavioural CAM supplies hits per mask, the expected result
// stream is the mask-ordered concatenation of those hits, and a monitor compares.
module tb_cam_search_ctrl;
   import cam_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cam_search_ctrl_if bus ();

   cam_search_ctrl #(.FIFO_DEPTH(8), .HIT_TIMEOUT(15)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int       n_tests = 0;
   int       n_fail  = 0;
   cam_res_t exp_q [$];
   cam_res_t cam_q [8][$];
   bit       pers [8];
   int       pers_idx, n_ack, n_res, done_cnt, cyc, arm0_cyc, done_cyc, exp_mask, exp_hits;
   logic [2:0] exp_strb;
   bit       ready_force;
   logic     ready_val;
   bit       prev_en;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic cam_res_t pers_gen(input int m, input int i);
      cam_res_t r;
      r.mask = 3'(m);
      r.addr = 8'(i);
      r.data = 32'h5000_0000 + 32'(i);
      return r;
   endfunction

   task automatic add_hit(input int m, input logic [7:0] addr, input logic [31:0] data);
      cam_res_t r;
      r.mask = 3'(m);
      r.addr = addr;
      r.data = data;
      cam_q[m].push_back(r);
   endtask

   task automatic clear_model();
      for (int m = 0; m < 8; m++) begin
         cam_q[m].delete();
         pers[m] = 1'b0;
      end
      pers_idx = 0;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_busy"},      bus.busy,        0);
      check({tag, "_done"},      bus.done,        0);
      check({tag, "_cam_mask"},  bus.cam_mask,    0);
      check({tag, "_cam_strb"},  bus.cam_strb,    0);
      check({tag, "_mask_en"},   bus.cam_mask_en, 0);
      check({tag, "_cam_ack"},   bus.cam_ack,     0);
      check({tag, "_res_valid"}, bus.res_valid,   0);
      check({tag, "_res_data"},  bus.res_data,    0);
      check({tag, "_res_addr"},  bus.res_addr,    0);
      check({tag, "_res_mask"},  bus.res_mask,    0);
      check({tag, "_hit_cnt"},   bus.hit_cnt,     0);
   endtask

   // Expected stream: masks ascend, each contributes its hits in order, capped at 256.
   task automatic begin_sweep(input logic [2:0] strb);
      exp_hits = 0;
      for (int m = 0; m < 8; m++) begin
         if (pers[m]) begin
            for (int i = 0; i < 256; i++) begin
               exp_q.push_back(pers_gen(m, i));
               exp_hits++;
            end
         end else begin
            for (int i = 0; i < cam_q[m].size() && i < 256; i++) begin
               exp_q.push_back(cam_q[m][i]);
               exp_hits++;
            end
         end
      end
      exp_mask = 0;
      exp_strb = strb;
      n_ack    = 0;
      @(negedge clk);
      bus.start    = 1'b1;
      bus.strb_cfg = strb;
      @(negedge clk);
      bus.start    = 1'b0;
      bus.strb_cfg = 3'($urandom);
   endtask

   task automatic finish_sweep(input int budget);
      bit seen = 1'b0;
      for (int c = 0; c < budget && !seen; c++) begin
         @(negedge clk);
         if (bus.done) begin
            seen = 1'b1;
            check("hit_cnt", bus.hit_cnt, 64'(exp_hits));
            check("acks_per_hit", 64'(n_ack), 64'(exp_hits));
         end
      end
      check("sweep_done", seen, 1);
      @(negedge clk);
      check("done_one_cycle", bus.done, 0);
      check("idle_busy", bus.busy, 0);
      for (int c = 0; c < budget && exp_q.size() > 0; c++) @(negedge clk);
      check("results_drained", 64'(exp_q.size()), 0);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   initial begin : ready_drv
      bus.res_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         bus.res_ready = ready_force ? ready_val : 1'($urandom_range(0, 1));
      end
   end

   initial begin : cam_model
      int       m;
      cam_res_t r;
      bus.cam_hit  = 1'b0;
      bus.cam_addr = '0;
      bus.cam_data = '0;
      forever begin
         @(negedge clk);
         m = int'(bus.cam_mask);
         if (bus.cam_ack) begin
            n_ack++;
            if (pers[m]) pers_idx++;
            else if (cam_q[m].size() > 0) void'(cam_q[m].pop_front());
         end
         if (bus.cam_mask_en && pers[m]) begin
            r = pers_gen(m, pers_idx);
            bus.cam_hit = 1'b1;
         end else if (bus.cam_mask_en && cam_q[m].size() > 0) begin
            r = cam_q[m][0];
            bus.cam_hit = 1'b1;
         end else begin
            r.addr = 8'($urandom);
            r.data = $urandom;
            r.mask = '0;
            bus.cam_hit = 1'b0;
         end
         bus.cam_addr = r.addr;
         bus.cam_data = r.data;
      end
   end

   initial begin : monitor
      cam_res_t e;
      forever begin
         @(negedge clk);
         if (!rst && bus.res_valid && bus.res_ready) begin
            n_res++;
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL res_extra: got mask %0d addr %0h data %0h, expected no result",
                        bus.res_mask, bus.res_addr, bus.res_data);
            end else begin
               e = exp_q.pop_front();
               check("res_mask", bus.res_mask, e.mask);
               check("res_addr", bus.res_addr, e.addr);
               check("res_data", bus.res_data, e.data);
            end
         end
         if (!rst && bus.cam_mask_en && !prev_en) begin
            if (exp_mask == 0) arm0_cyc = cyc;
            check("mask_seq", bus.cam_mask, 64'(exp_mask));
            check("strb_latched", bus.cam_strb, exp_strb);
            exp_mask++;
         end
         if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         prev_en = bus.cam_mask_en;
      end
   end

   initial begin : watchdog
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int  base, acks, n_res0, done0;
      bit  found;
      rst          = 1'b1;
      bus.start    = 1'b0;
      bus.strb_cfg = '0;
      ready_force  = 1'b1;
      ready_val    = 1'b0;
      clear_model();
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst = 1'b0;

      // Empty CAM: eight masks of ARM + 15 WAIT + NEXT each.
      ready_force = 1'b0;
      n_res0 = n_res;
      begin_sweep(3'b111);
      finish_sweep(400);
      check("empty_arm_to_done", 64'(done_cyc - arm0_cyc), 136);
      check("empty_no_results", 64'(n_res - n_res0), 0);

      // Three hits under mask 2.
      clear_model();
      add_hit(2, 8'h10, 32'hA000_0001);
      add_hit(2, 8'h11, 32'hA000_0002);
      add_hit(2, 8'h12, 32'hA000_0003);
      begin_sweep(3'($urandom));
      finish_sweep(600);

      // Back-pressure: 10 hits, consumer stalled, FIFO holds 8.
      clear_model();
      for (int i = 0; i < 10; i++) add_hit(0, 8'(i + 8'h40), $urandom);
      ready_force = 1'b1;
      ready_val   = 1'b0;
      begin_sweep(3'b010);
      repeat (60) @(negedge clk);
      base = n_ack;
      repeat (40) @(negedge clk);
      check("bp_no_ack_in_stall", 64'(n_ack - base), 0);
      check("bp_acks", 64'(n_ack), 8);
      check("bp_mask_held", bus.cam_mask, 0);
      check("bp_mask_en", bus.cam_mask_en, 1);
      check("bp_res_valid", bus.res_valid, 1);
      check("bp_hit_cnt", bus.hit_cnt, 8);
      ready_force = 1'b0;
      finish_sweep(2000);

      // Persistent hits under mask 5 hit the 256 cap, then mask 6 is visited.
      clear_model();
      pers[5] = 1'b1;
      add_hit(6, 8'h66, 32'hC0DE_0006);
      begin_sweep(3'b101);
      finish_sweep(4000);

      // Reset during the ACK of the second hit.
      clear_model();
      for (int i = 0; i < 4; i++) add_hit(0, 8'(i + 1), 32'hD000_0000 + 32'(i));
      ready_force = 1'b1;
      ready_val   = 1'b0;
      begin_sweep(3'b101);
      acks  = 0;
      found = 1'b0;
      for (int c = 0; c < 200 && !found; c++) begin
         @(negedge clk);
         if (bus.cam_ack) acks++;
         if (acks == 2) found = 1'b1;
      end
      check("rst_second_ack_seen", found, 1);
      rst = 1'b1;
      @(negedge clk);
      check_zero("mid_rst");
      rst = 1'b0;
      exp_q.delete();
      clear_model();
      base = n_ack;
      repeat (5) @(negedge clk);
      check("no_ack_after_rst", 64'(n_ack - base), 0);
      check("idle_after_rst", bus.busy, 0);
      ready_force = 1'b0;
      add_hit(3, 8'h33, 32'h3333_0003);
      add_hit(3, 8'h34, 32'h3333_0004);
      begin_sweep(3'($urandom));
      finish_sweep(600);

      // Start while busy is ignored.
      clear_model();
      add_hit(1, 8'h01, 32'h1111_0001);
      add_hit(4, 8'h04, 32'h4444_0004);
      done0 = done_cnt;
      begin_sweep(3'b011);
      repeat (30) @(negedge clk);
      bus.start    = 1'b1;
      bus.strb_cfg = 3'b100;
      @(negedge clk);
      bus.start    = 1'b0;
      finish_sweep(600);
      repeat (20) @(negedge clk);
      check("single_done", 64'(done_cnt - done0), 1);

      // Randomised sweeps.
      for (int s = 0; s < 3; s++) begin
         clear_model();
         for (int m = 0; m < 8; m++) begin
            int n = $urandom_range(0, 3);
            for (int i = 0; i < n; i++) add_hit(m, 8'($urandom), $urandom);
         end
         begin_sweep(3'($urandom));
         finish_sweep(2000);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
